// File: rtl/ps2_button_mapper_if.sv
// ps2_button_mapper_if
//   Input bus of the keyboard-to-button mapper: the hps_io ps2_key stream
//   and the map-table write port.
//   ps2_key  [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   map_wr   map table write strobe
//   map_addr map entry index
//   map_data {extended, code}; 9'h000 marks an unused entry
//   master: the side that drives the bus (host / OSD logic)
//   slave : the mapper
interface ps2_button_mapper_if;
  logic [10:0] ps2_key;
  logic        map_wr;
  logic [4:0]  map_addr;
  logic [8:0]  map_data;

  modport master (output ps2_key, map_wr, map_addr, map_data);
  modport slave  (input  ps2_key, map_wr, map_addr, map_data);
endinterface

// File: rtl/ps2_button_mapper.sv
// ps2_button_mapper
//   Maps PS/2 key events onto NUM_BUTTONS front-panel buttons through a
//   runtime-loadable table, stretches short taps to at least MIN_HOLD
//   cycles and ORs in alternate (joystick) sources.
//   clk       system clock
//   reset     synchronous active-high reset
//   bus       ps2_key stream and map write port (slave side)
//   joy       alternate active-high button sources
//   buttons   registered button state
//   key_event one-cycle pulse when any mapped key changes state
//   any_down  registered OR of buttons
module ps2_button_mapper #(
  parameter int NUM_BUTTONS = 12,
  parameter int MIN_HOLD    = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_button_mapper_if.slave     bus,
  input  logic [NUM_BUTTONS-1:0] joy,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   key_event,
  output logic                   any_down
);

  // With MIN_HOLD = 0 the counter is kept one bit wide and always stays 0.
  localparam int CW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD);

  // The table is deliberately outside reset so it survives an OSD reset.
  logic [8:0]             map_tbl [NUM_BUTTONS] = '{default: 9'h000};
  logic [NUM_BUTTONS-1:0] key_state;
  logic [CW-1:0]          hold_cnt [NUM_BUTTONS];
  logic                   old_toggle;

  logic                   key_change;
  logic [8:0]             key_id;
  logic [NUM_BUTTONS-1:0] wr_hit;
  logic [NUM_BUTTONS-1:0] match;
  logic [NUM_BUTTONS-1:0] ks_next;
  logic [CW-1:0]          hold_next [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] btn_next;

  always_comb begin
    key_change = (bus.ps2_key[10] != old_toggle);
    key_id     = bus.ps2_key[8:0];
    wr_hit     = '0;
    match      = '0;
    ks_next    = key_state;
    btn_next   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hold_next[i] = hold_cnt[i];
      // Out-of-range write addresses match no entry and are dropped.
      wr_hit[i] = bus.map_wr && (bus.map_addr == 5'(i));
      match[i]  = key_change && (map_tbl[i] != 9'h000) && (map_tbl[i] == key_id);
      // A remap clears the entry's key state and beats a same-cycle event.
      if (wr_hit[i])
        ks_next[i] = 1'b0;
      else if (match[i])
        ks_next[i] = bus.ps2_key[9];
      // Only a real 0->1 edge reloads, so typematic repeats do not extend.
      if (ks_next[i] && !key_state[i])
        hold_next[i] = HOLD_LOAD;
      else if (hold_cnt[i] != '0)
        hold_next[i] = hold_cnt[i] - CW'(1);
      btn_next[i] = ks_next[i] | (hold_next[i] != '0) | joy[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUTTONS; i++)
      if (wr_hit[i])
        map_tbl[i] <= bus.map_data;
  end

  always_ff @(posedge clk) begin
    // old_toggle tracks the input even in reset so no event follows it.
    old_toggle <= bus.ps2_key[10];
    if (reset) begin
      key_state <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
        hold_cnt[i] <= '0;
      buttons   <= '0;
      key_event <= 1'b0;
      any_down  <= 1'b0;
    end else begin
      key_state <= ks_next;
      for (int i = 0; i < NUM_BUTTONS; i++)
        hold_cnt[i] <= hold_next[i];
      buttons   <= btn_next;
      key_event <= |(ks_next ^ key_state);
      any_down  <= |btn_next;
    end
  end

endmodule

// File: tb/tb_ps2_button_mapper.sv
module tb_ps2_button_mapper;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] joy;
  logic [11:0] btn0, btn16;
  logic        ev0, ev16, any0, any16;
  logic        tog;
  int          n_vec = 0;
  int          n_err = 0;

  ps2_button_mapper_if bus ();

  ps2_button_mapper #(.NUM_BUTTONS(12), .MIN_HOLD(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus), .joy(joy),
    .buttons(btn0), .key_event(ev0), .any_down(any0));

  ps2_button_mapper #(.NUM_BUTTONS(12), .MIN_HOLD(16)) u_dut16 (
    .clk(clk), .reset(reset), .bus(bus), .joy(joy),
    .buttons(btn16), .key_event(ev16), .any_down(any16));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic map_write(input logic [4:0] addr, input logic [8:0] data);
    bus.map_wr   = 1'b1;
    bus.map_addr = addr;
    bus.map_data = data;
    step();
    bus.map_wr   = 1'b0;
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, ext, code};
    step();
  endtask

  initial begin
    int hi, hi0, fall_c;
    logic ev_rep;
    reset = 1'b1;
    joy = '0;
    tog = 1'b0;
    bus.ps2_key = '0;
    bus.map_wr = 1'b0;
    bus.map_addr = '0;
    bus.map_data = '0;
    step(); step();
    chk("rst_buttons", btn0, 12'h000);
    chk("rst_event", ev0, 0);
    chk("rst_any", any0, 0);
    reset = 1'b0;
    step();

    // map and press/release
    map_write(5'd0, 9'h01C);
    key(1'b1, 1'b0, 8'h1C);
    chk("press_buttons", btn0, 12'h001);
    chk("press_event", ev0, 1);
    chk("press_any", any0, 1);
    step();
    chk("event_single", ev0, 0);
    chk("held_buttons", btn0, 12'h001);
    key(1'b0, 1'b0, 8'h1C);
    chk("release_buttons", btn0, 12'h000);
    chk("release_event", ev0, 1);
    chk("release_any", any0, 0);

    // extended and shared keys
    map_write(5'd0, 9'h000);
    map_write(5'd3, 9'h11C);
    map_write(5'd7, 9'h11C);
    map_write(5'd5, 9'h01C);
    key(1'b1, 1'b1, 8'h1C);
    chk("ext_press", btn0, 12'h088);
    key(1'b1, 1'b0, 8'h1C);
    chk("plain_press", btn0, 12'h0A8);
    key(1'b0, 1'b1, 8'h1C);
    chk("ext_release", btn0, 12'h020);
    key(1'b0, 1'b0, 8'h1C);
    chk("plain_release", btn0, 12'h000);

    // back-to-back events give consecutive pulses
    key(1'b1, 1'b1, 8'h1C);
    chk("b2b_ev1", ev0, 1);
    key(1'b0, 1'b1, 8'h1C);
    chk("b2b_ev2", ev0, 1);
    chk("b2b_buttons", btn0, 12'h000);

    // unmapped code, out-of-range write ignored, idle toggle
    map_write(5'd12, 9'h02A);
    step();
    key(1'b1, 1'b0, 8'h2A);
    chk("unmapped_buttons", btn0, 12'h000);
    chk("unmapped_event", ev0, 0);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("idle_event", ev0, 0);
      chk("idle_buttons", btn0, 12'h000);
    end
    key(1'b0, 1'b0, 8'h2A);

    // hold stretch: tap press at 0, release at 3
    map_write(5'd1, 9'h016);
    step();
    hi = 0; hi0 = 0; fall_c = -1;
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h16};
    for (int c = 0; c < 30; c++) begin
      if (c == 3) begin
        tog = ~tog;
        bus.ps2_key = {tog, 1'b0, 1'b0, 8'h16};
      end
      step();
      hi += int'(btn16[1]);
      hi0 += int'(btn0[1]);
      if (fall_c < 0 && hi > 0 && !btn16[1]) fall_c = c;
    end
    chk("tap_len", hi, 16);
    chk("tap_fall", fall_c, 16);
    chk("tap_len_nohold", hi0, 3);

    // typematic repeat at 5 must not reload, release at 8
    hi = 0; ev_rep = 1'bx;
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h16};
    for (int c = 0; c < 30; c++) begin
      if (c == 5) begin
        tog = ~tog;
        bus.ps2_key = {tog, 1'b1, 1'b0, 8'h16};
      end
      if (c == 8) begin
        tog = ~tog;
        bus.ps2_key = {tog, 1'b0, 1'b0, 8'h16};
      end
      step();
      hi += int'(btn16[1]);
      if (c == 5) ev_rep = ev16;
    end
    chk("typematic_len", hi, 16);
    chk("typematic_event", ev_rep, 0);

    // remap while held
    map_write(5'd5, 9'h000);
    map_write(5'd0, 9'h01C);
    key(1'b1, 1'b0, 8'h1C);
    chk("remap_held", btn0, 12'h001);
    map_write(5'd0, 9'h01A);
    chk("remap_cleared", btn0, 12'h000);
    chk("remap_event", ev0, 1);
    key(1'b1, 1'b0, 8'h1A);
    chk("remap_new_key", btn0, 12'h001);
    key(1'b0, 1'b0, 8'h1A);
    chk("remap_release", btn0, 12'h000);

    // write and matching event on the same cycle: write wins for that entry
    map_write(5'd2, 9'h01A);
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h1A};
    bus.map_wr = 1'b1;
    bus.map_addr = 5'd0;
    bus.map_data = 9'h01A;
    step();
    bus.map_wr = 1'b0;
    chk("wr_vs_event", btn0, 12'h004);
    key(1'b0, 1'b0, 8'h1A);
    chk("wr_vs_release", btn0, 12'h000);
    for (int c = 0; c < 20; c++) step();

    // reset mid-hold with toggle at 1
    key(1'b1, 1'b0, 8'h16);
    if (!tog) key(1'b1, 1'b0, 8'h16);
    step(); step();
    chk("midhold_btn16", btn16, 12'h002);
    reset = 1'b1;
    step();
    chk("rst_mid_btn16", btn16, 12'h000);
    chk("rst_mid_ev16", ev16, 0);
    chk("rst_mid_any16", any16, 0);
    chk("rst_mid_btn0", btn0, 12'h000);
    reset = 1'b0;
    step();
    chk("post_rst_ev16", ev16, 0);
    chk("post_rst_ev0", ev0, 0);
    chk("post_rst_btn16", btn16, 12'h000);
    step();
    chk("post_rst_btn16_b", btn16, 12'h000);

    joy = 12'h800;
    step();
    chk("joy_buttons", btn0, 12'h800);
    chk("joy_any", any0, 1);
    joy = 12'h000;
    step();
    chk("joy_off", btn0, 12'h000);
    chk("joy_off_any", any0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ps2_button_mapper.md
# ps2_button_mapper

Parametrised keyboard-to-button mapper for the front-panel inputs of Companion-style cores. It sits between `hps_io`'s `ps2_key` stream and the `system` input bus. It replaces a hard-wired scan-code case statement with a runtime-loadable map of NUM_BUTTONS entries, supporting extended (E0) codes and several buttons sharing one key. It adds a minimum-hold stretcher, so short taps are still seen by a slowly polling CPU, and ORs in joystick/alternate sources.

## Interface

Parameters:
- NUM_BUTTONS, 12, number of button outputs and map entries (1..32)
- MIN_HOLD, 65536, minimum asserted cycles after a key press; 0 disables stretching

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scan code
- joy  in  NUM_BUTTONS  alternate active-high sources, OR-merged per button
- map_wr  in  1  write strobe for the map table
- map_addr  in  5  entry index; writes with index ≥ NUM_BUTTONS are ignored
- map_data  in  9  {extended, code}; 9'h000 means entry unused
- buttons  out  NUM_BUTTONS  registered active-high button state
- key_event  out  1  one-cycle pulse when any mapped key changes state
- any_down  out  1  registered OR of `buttons`

## Operation

- **Map table**
  - NUM_BUTTONS × 9-bit registers.
  - Not cleared by reset, so it survives OSD reset.
  - Power-up value is 9'h000 (all entries unused).
- **Event detection**
  - `old_toggle` register; an event occurs on a cycle where `ps2_key[10] != old_toggle`.
  - `old_toggle` updates every cycle.
- **Matching**
  - On an event, {ps2_key[8], ps2_key[7:0]} is compared against every entry in parallel.
  - Each nonzero matching entry i sets `key_state[i] <= ps2_key[9]`.
  - Entries holding 9'h000 never match.
  - Non-matching events change nothing.
- **Hold stretcher** (per button i, counter width clog2(MIN_HOLD+1))
  - On a 0→1 transition of `key_state[i]`, `hold_cnt[i]` loads MIN_HOLD.
  - Otherwise it decrements each cycle while nonzero.
  - Typematic repeats (press while already down) do not reload it.
- **Outputs**
  - `buttons[i] <= key_state_next[i] | (hold_cnt_next[i] != 0) | joy[i]`.
  - `key_event <= 1` iff at least one `key_state` bit changes this cycle.
  - `any_down <= |buttons_next`.
- **Map write**
  - On `map_wr` with a valid index, entry `map_addr` is overwritten.
  - `key_state[map_addr]` is cleared in the same cycle, so no button is stuck from a remap; `hold_cnt` is untouched.
  - The new entry matches events from the next cycle on.
- **Simultaneous map write and matching event on the same entry**: the write wins. `key_state` is cleared and the old mapping's event is discarded for that entry only; other entries process the event normally.
- **Reset**
  - `key_state`, `hold_cnt`, `buttons`, `key_event`, `any_down` are all 0.
  - `old_toggle <= ps2_key[10]`, so no spurious event follows reset.

## Timing

- Key press or release sampled at edge E: `buttons` and `key_event` are valid after E (1 cycle from the input change).
- `joy` to `buttons`: 1 cycle.
- Short tap (press at E, release at E+k, k < MIN_HOLD): the button is high for exactly MIN_HOLD cycles and falls after edge E+MIN_HOLD.
- Release at k ≥ MIN_HOLD: the button falls after the release edge.
- MIN_HOLD = 0: the button follows `key_state` exactly.
- `key_event` is a single-cycle pulse; back-to-back events on consecutive cycles give consecutive pulses.
- `any_down` is coincident with `buttons`.
- Reset asserted mid-hold: all outputs are 0 after the reset edge. The counters restart only on new presses after reset deasserts.

## Test plan

- **Map and press/release**, NUM_BUTTONS=12, MIN_HOLD=0.
  - Stimulus: load entry 0 = 9'h01C, then toggle press code 1C, later release.
  - Required: `buttons` = 12'h001 one cycle after the press and 0 one cycle after the release; `key_event` pulses both times.
- **Extended and shared keys.**
  - Stimulus: entries 3 and 7 = 9'h11C, entry 5 = 9'h01C; press E0-1C.
  - Required: `buttons` = 12'h088. Press plain 1C → 12'h0A8.
- **Hold stretch**, MIN_HOLD=16.
  - Stimulus: press at cycle 0, release at cycle 3.
  - Required: `buttons[0]` high for exactly 16 cycles. A typematic re-press at cycle 5 does not extend it.
- **Unmapped and no-event cases.**
  - Stimulus: press code 2A with no entry mapped to it; then present an unchanged toggle for 100 cycles.
  - Required: `buttons` = 0, `key_event` = 0 throughout.
- **Remap while held.**
  - Stimulus: hold 1C on entry 0 (MIN_HOLD=0), then write entry 0 = 9'h01A.
  - Required: `buttons[0]` = 0 the next cycle. Pressing 1A then sets it.
- **Reset and joy.**
  - Stimulus: assert reset mid-hold while toggle is 1.
  - Required: all outputs 0 and no event on deassert. `joy` = 12'h800 gives `buttons` = 12'h800 and `any_down` = 1 one cycle later.
